tick_gen: RTL and testbench

Multi-channel parametrised clock-enable generator; successor to the single-channel divider.
- Each channel produces a 1-cycle tick every div+1 cycles.
- Each channel also produces a 50%-duty square output.
- Per-channel enable; shadowed divisor that reloads glitch-free.
- Feeds game-logic timers, display refresh and button debouncers; all run on the single system clock, never as derived clocks.

---
 rtl/tick_gen_pkg.sv | 17 +
 rtl/tick_gen_ch.sv | 88 ++++++++
 rtl/tick_gen_chk.sv | 23 ++
 rtl/tick_gen.sv | 50 +++++
 tb/tb_tick_gen.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/tick_gen_pkg.sv
// Shared constants and per-channel status type for the tick_gen clock-enable generator.
// Optional phase-align input is enabled with TICK_GEN_SYNC_EN.
package tick_gen_pkg;

   localparam int TG_WIDTH_DEF = 16;
   localparam int TG_NCH_MAX   = 16;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } tg_state_e;

   function automatic tg_state_e tg_state_f(input logic i_busy);
      return i_busy ? RUN : IDLE;
   endfunction

endpackage

// File: rtl/tick_gen_ch.sv
// One tick_gen channel: counter, shadow divisor, tick pulse and square output.
// Adds the sync_clr input when TICK_GEN_SYNC_EN is defined.
module tick_gen_ch
   import tick_gen_pkg::*;
#(
   parameter int          WIDTH   = TG_WIDTH_DEF,
   parameter int unsigned RST_DIV = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
`ifdef TICK_GEN_SYNC_EN
   input  logic             sync_clr,
`endif
   input  logic [WIDTH-1:0] div,
   output logic             tick,
   output logic             sq,
   output logic             busy
);

   localparam logic [WIDTH-1:0] LP_RST_DIV = WIDTH'(RST_DIV);
   localparam logic [WIDTH-1:0] LP_ZERO    = WIDTH'(0);
   localparam logic [WIDTH-1:0] LP_ONE     = WIDTH'(1);

   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_div;
   logic             r_tick;
   logic             r_sq;
   logic             r_busy;

   logic [WIDTH-1:0] w_cnt_nxt;
   logic [WIDTH-1:0] w_div_nxt;
   logic             w_tick_nxt;
   logic             w_sq_nxt;
   logic             w_restart;
   logic             w_tc;

   // The first enabled edge (busy still low) only loads the divisor, so a
   // period always starts from a freshly sampled div and reset never ticks.
`ifdef TICK_GEN_SYNC_EN
   assign w_restart = ~r_busy | sync_clr;
`else
   assign w_restart = ~r_busy;
`endif
   assign w_tc = (r_cnt == r_div);

   // Next-state selection in priority order: idle/restart, terminal count, count.
   always_comb begin
      w_cnt_nxt  = r_cnt;
      w_div_nxt  = r_div;
      w_tick_nxt = 1'b0;
      w_sq_nxt   = r_sq;
      if (!en || w_restart) begin
         w_cnt_nxt = LP_ZERO;
         w_sq_nxt  = 1'b0;
         w_div_nxt = div;
      end else if (w_tc) begin
         w_cnt_nxt  = LP_ZERO;
         w_tick_nxt = 1'b1;
         w_sq_nxt   = ~r_sq;
         w_div_nxt  = div;
      end else begin
         w_cnt_nxt = r_cnt + LP_ONE;
      end
   end

   // Channel state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= LP_ZERO;
         r_div  <= LP_RST_DIV;
         r_tick <= 1'b0;
         r_sq   <= 1'b0;
         r_busy <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_div  <= w_div_nxt;
         r_tick <= w_tick_nxt;
         r_sq   <= w_sq_nxt;
         r_busy <= en;
      end
   end

   assign tick = r_tick;
   assign sq   = r_sq;
   assign busy = r_busy;

endmodule

// File: rtl/tick_gen_chk.sv
// Property checker for tick_gen outputs; an idle channel must be quiet.
// Independent of TICK_GEN_SYNC_EN.
module tick_gen_chk
   import tick_gen_pkg::*;
#(
   parameter int NCH = 4
) (
   input logic           clk,
   input logic           rst,
   input logic [NCH-1:0] tick,
   input logic [NCH-1:0] sq,
   input logic [NCH-1:0] busy
);

   for (genvar i = 0; i < NCH; i++) begin : g_chk
      tg_state_e w_state;
      assign w_state = tg_state_f(busy[i]);

      a_idle_quiet: assert property (@(posedge clk) disable iff (rst)
         (w_state == IDLE) |-> (!tick[i] && !sq[i]));
   end

endmodule

// File: rtl/tick_gen.sv
// Multi-channel clock-enable generator: NCH independent tick/square channels.
// Define TICK_GEN_SYNC_EN to add the sync_clr phase-align input.
module tick_gen
   import tick_gen_pkg::*;
#(
   parameter int          NCH     = 4,
   parameter int          WIDTH   = TG_WIDTH_DEF,
   parameter int unsigned RST_DIV = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH-1:0]       en,
`ifdef TICK_GEN_SYNC_EN
   input  logic                 sync_clr,
`endif
   input  logic [NCH*WIDTH-1:0] div,
   output logic [NCH-1:0]       tick,
   output logic [NCH-1:0]       sq,
   output logic [NCH-1:0]       busy
);

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      tick_gen_ch #(
         .WIDTH   (WIDTH),
         .RST_DIV (RST_DIV)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .en       (en[i]),
`ifdef TICK_GEN_SYNC_EN
         .sync_clr (sync_clr),
`endif
         .div      (div[i*WIDTH +: WIDTH]),
         .tick     (tick[i]),
         .sq       (sq[i]),
         .busy     (busy[i])
      );
   end

   tick_gen_chk #(
      .NCH (NCH)
   ) u_chk (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .sq   (sq),
      .busy (busy)
   );

endmodule

// File: tb/tb_tick_gen.sv
// Directed bench for tick_gen: vector table plus multi-cycle corner sequences.
// The sync_clr sequence is built only when TICK_GEN_SYNC_EN is defined.
module tb_tick_gen;

   localparam int NCH   = 4;
   localparam int WIDTH = 16;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NCH-1:0]       en;
   logic [NCH*WIDTH-1:0] div;
`ifdef TICK_GEN_SYNC_EN
   logic                 sync_clr;
`endif
   logic [NCH-1:0]       tick;
   logic [NCH-1:0]       sq;
   logic [NCH-1:0]       busy;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [NCH-1:0]       en;
      logic [NCH*WIDTH-1:0] div;
      logic [NCH-1:0]       tick;
      logic [NCH-1:0]       sq;
      logic [NCH-1:0]       busy;
   } vec_t;

   vec_t        vecs [13];
   logic [3:0]  exp5 [6];
   logic        exp_t;
   logic        exp_sq;
   logic        exp_busy;

   always #5 clk = ~clk;

   tick_gen #(
      .NCH     (NCH),
      .WIDTH   (WIDTH),
      .RST_DIV (0)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
`ifdef TICK_GEN_SYNC_EN
      .sync_clr (sync_clr),
`endif
      .div      (div),
      .tick     (tick),
      .sq       (sq),
      .busy     (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_div(input int ch, input logic [WIDTH-1:0] val);
      div[ch*WIDTH +: WIDTH] = val;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en  = '0;
      div = '0;
`ifdef TICK_GEN_SYNC_EN
      sync_clr = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      // ch0 div=3 ticks at edges 4,8,12; ch1 div=0 ticks from edge 1 on.
      vecs[0]  = '{4'b0011, 64'h3, 4'b0000, 4'b0000, 4'b0011};
      vecs[1]  = '{4'b0011, 64'h3, 4'b0010, 4'b0010, 4'b0011};
      vecs[2]  = '{4'b0011, 64'h3, 4'b0010, 4'b0000, 4'b0011};
      vecs[3]  = '{4'b0011, 64'h3, 4'b0010, 4'b0010, 4'b0011};
      vecs[4]  = '{4'b0011, 64'h3, 4'b0011, 4'b0001, 4'b0011};
      vecs[5]  = '{4'b0011, 64'h3, 4'b0010, 4'b0011, 4'b0011};
      vecs[6]  = '{4'b0011, 64'h3, 4'b0010, 4'b0001, 4'b0011};
      vecs[7]  = '{4'b0011, 64'h3, 4'b0010, 4'b0011, 4'b0011};
      vecs[8]  = '{4'b0011, 64'h3, 4'b0011, 4'b0000, 4'b0011};
      vecs[9]  = '{4'b0011, 64'h3, 4'b0010, 4'b0010, 4'b0011};
      vecs[10] = '{4'b0011, 64'h3, 4'b0010, 4'b0000, 4'b0011};
      vecs[11] = '{4'b0011, 64'h3, 4'b0010, 4'b0010, 4'b0011};
      vecs[12] = '{4'b0011, 64'h3, 4'b0011, 4'b0001, 4'b0011};

      exp5[0] = 4'b0000;
      exp5[1] = 4'b0010;
      exp5[2] = 4'b0010;
      exp5[3] = 4'b0010;
      exp5[4] = 4'b0011;
      exp5[5] = 4'b1010;

      // Reset held with inputs already active: outputs must stay at reset values.
      rst = 1'b1;
      en  = vecs[0].en;
      div = vecs[0].div;
`ifdef TICK_GEN_SYNC_EN
      sync_clr = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check("rst_tick", 32'(tick), 32'h0);
      check("rst_sq",   32'(sq),   32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      rst = 1'b0;

      for (int k = 0; k < 13; k++) begin
         en  = vecs[k].en;
         div = vecs[k].div;
         step();
         check($sformatf("vec%0d_tick", k), 32'(tick), 32'(vecs[k].tick));
         check($sformatf("vec%0d_sq", k),   32'(sq),   32'(vecs[k].sq));
         check($sformatf("vec%0d_busy", k), 32'(busy), 32'(vecs[k].busy));
      end

      // ch2 div=9, shrink to 2 at count 5: period completes at 10, then 3.
      do_reset();
      set_div(2, 16'd9);
      en     = 4'b0100;
      exp_sq = 1'b0;
      for (int e = 0; e < 28; e++) begin
         step();
         exp_t = (e == 10) || (e == 20) || (e == 23) || (e == 26);
         if (exp_t) exp_sq = ~exp_sq;
         check($sformatf("t3_tick_e%0d", e), 32'(tick[2]), 32'(exp_t));
         check($sformatf("t3_sq_e%0d", e),   32'(sq[2]),   32'(exp_sq));
         if (e == 15) set_div(2, 16'd2);
      end

      // ch3 div=4, en off for three edges mid-period, then restart.
      do_reset();
      set_div(3, 16'd4);
      en     = 4'b1000;
      exp_sq = 1'b0;
      for (int e = 0; e < 23; e++) begin
         step();
         exp_t    = (e == 5) || (e == 16) || (e == 21);
         exp_busy = !((e >= 8) && (e <= 10));
         if (!exp_busy) exp_sq = 1'b0;
         else if (exp_t) exp_sq = ~exp_sq;
         check($sformatf("t4_tick_e%0d", e), 32'(tick[3]), 32'(exp_t));
         check($sformatf("t4_sq_e%0d", e),   32'(sq[3]),   32'(exp_sq));
         check($sformatf("t4_busy_e%0d", e), 32'(busy[3]), 32'(exp_busy));
         if (e == 7)  en = 4'b0000;
         if (e == 10) en = 4'b1000;
      end

      // Async reset between edges with all channels running.
      do_reset();
      set_div(0, 16'd3);
      set_div(1, 16'd0);
      set_div(2, 16'd9);
      set_div(3, 16'd4);
      en = 4'b1111;
      repeat (6) step();
      check("t5_pre_tick", 32'(tick), 32'(4'b1010));
      check("t5_pre_busy", 32'(busy), 32'(4'b1111));
      #3;
      rst = 1'b1;
      #1;
      check("t5_async_tick", 32'(tick), 32'h0);
      check("t5_async_sq",   32'(sq),   32'h0);
      check("t5_async_busy", 32'(busy), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int e = 0; e < 6; e++) begin
         step();
         check($sformatf("t5_tick_e%0d", e), 32'(tick), 32'(exp5[e]));
      end

`ifdef TICK_GEN_SYNC_EN
      // ch0 div=3 and ch1 div=5 out of phase; sync_clr at edges 6 and 14.
      do_reset();
      set_div(0, 16'd3);
      set_div(1, 16'd5);
      en = 4'b0001;
      for (int e = 0; e < 22; e++) begin
         step();
         check($sformatf("t6_tick0_e%0d", e), 32'(tick[0]),
               32'((e == 4) || (e == 10) || (e == 18)));
         check($sformatf("t6_tick1_e%0d", e), 32'(tick[1]),
               32'((e == 12) || (e == 20)));
         if (e == 6) check("t6_sq_clr", 32'(sq[1:0]), 32'h0);
         if (e == 1) en = 4'b0011;
         sync_clr = (e == 5) || (e == 13);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
